// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared widths, op encodings and FSM states for the iterative MDU
package mdu_pkg;

  localparam int MDU_W     = 32;
  localparam int MDU_ITERS = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIXUP,
    ST_DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one restoring divide step on magnitudes
module mdu_div_step
  import mdu_pkg::*;
(
  input  logic [MDU_W-1:0] rem,
  input  logic [MDU_W-1:0] quot,
  input  logic [MDU_W-1:0] divisor,
  output logic [MDU_W-1:0] rem_next,
  output logic [MDU_W-1:0] quot_next
);

  logic [MDU_W:0] shifted;
  logic [MDU_W:0] diff;

  always_comb begin
    shifted   = {rem, quot[MDU_W-1]};
    diff      = shifted - {1'b0, divisor};
    rem_next  = shifted[MDU_W-1:0];
    quot_next = {quot[MDU_W-2:0], 1'b0};
    // rem < divisor before the shift, so a non-borrowing difference always fits in MDU_W bits
    if (!diff[MDU_W]) begin
      rem_next     = diff[MDU_W-1:0];
      quot_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - radix-2 multiply / restoring divide engine with done pulse and cancel
// Optional MDU_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are zero.
module mdu_iter_core
  import mdu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [MDU_W-1:0]   src_a,
  input  logic [MDU_W-1:0]   src_b,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic [MDU_W-1:0]   hi_out,
  output logic [MDU_W-1:0]   lo_out
);

  mdu_state_e state_q, state_d;

  logic               is_div_q;
  logic               sign_a_q, sign_b_q;
  logic [2*MDU_W-1:0] mcand_q, acc_q;
  logic [MDU_W-1:0]   b_q, rem_q, quot_q;
  logic [5:0]         cnt_q;

  logic               op_signed, op_is_div, div_zero, issue;
  logic [MDU_W-1:0]   mag_a, mag_b, b_shr, rem_nx, quot_nx;
  logic [5:0]         cnt_inc;
  logic               iters_hit, mul_exit, neg_res;
  logic [2*MDU_W-1:0] prod_fix;
  logic [MDU_W-1:0]   quot_fix, rem_fix;

  assign op_signed = ~op[0];
  assign op_is_div = op[1];
  assign div_zero  = op_is_div && (src_b == '0);
  assign issue     = start && !cancel;
  assign mag_a     = (op_signed && src_a[MDU_W-1]) ? -src_a : src_a;
  assign mag_b     = (op_signed && src_b[MDU_W-1]) ? -src_b : src_b;

  assign b_shr     = b_q >> 1;
  assign cnt_inc   = cnt_q + 6'd1;
  assign iters_hit = (cnt_inc == 6'(MDU_ITERS));

`ifdef MDU_EARLY_TERM_EN
  assign mul_exit = iters_hit || (b_shr == '0);
`else
  assign mul_exit = iters_hit;
`endif

  assign neg_res  = sign_a_q ^ sign_b_q;
  assign prod_fix = neg_res ? -acc_q : acc_q;
  assign quot_fix = neg_res ? -quot_q : quot_q;
  assign rem_fix  = sign_a_q ? -rem_q : rem_q;

  mdu_div_step u_div_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (b_q),
    .rem_next  (rem_nx),
    .quot_next (quot_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          if (!op_is_div)    state_d = ST_MUL;
          else if (div_zero) state_d = ST_DONE;
          else               state_d = ST_DIV;
        end
      end
      ST_MUL:   if (mul_exit)  state_d = ST_FIXUP;
      ST_DIV:   if (iters_hit) state_d = ST_FIXUP;
      ST_FIXUP: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // The result is already registered in DONE, so cancel there must not swallow the pulse
    if (cancel && state_q != ST_DONE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            is_div_q <= op_is_div;
            sign_a_q <= op_signed && src_a[MDU_W-1];
            sign_b_q <= op_signed && src_b[MDU_W-1];
            mcand_q  <= {{MDU_W{1'b0}}, mag_a};
            acc_q    <= '0;
            b_q      <= mag_b;
            rem_q    <= '0;
            quot_q   <= mag_a;
            cnt_q    <= '0;
            if (div_zero) begin
              hi_out <= src_a;
              lo_out <= '1;
            end
          end
        end
        ST_MUL: begin
          if (b_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q <= mcand_q << 1;
          b_q     <= b_shr;
          cnt_q   <= cnt_inc;
        end
        ST_DIV: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          cnt_q  <= cnt_inc;
        end
        ST_FIXUP: begin
          if (!cancel) begin
            if (is_div_q) begin
              hi_out <= rem_fix;
              lo_out <= quot_fix;
            end else begin
              {hi_out, lo_out} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIXUP);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mdu_iter_core.sv
// tb/tb_mdu_iter_core.sv - self-checking bench for mdu_iter_core (honours MDU_EARLY_TERM_EN)
module tb_mdu_iter_core;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic        chk_en   = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;

  mdu_iter_core dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Architectural result: HI in [63:32], LO in [31:0]
  function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    int ai, bi;
    ai = a;
    bi = b;
    case (o)
      MDU_MULT: begin
        sp = 64'(ai) * 64'(bi);
        return sp;
      end
      MDU_MULTU: return {32'b0, a} * {32'b0, b};
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ai % bi), 32'(ai / bi)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Cycle (counted from the start edge) in which done is expected
  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
    logic [31:0] m;
    int bl;
    if (o[1]) return (b == 0) ? 1 : 34;
    m  = (o == MDU_MULT && b[31]) ? -b : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
`ifdef MDU_EARLY_TERM_EN
    return ((bl < 1) ? 1 : bl) + 2;
`else
    return (bl >= 0) ? 34 : 34;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(exp_busy));
      check("done", 64'(done), 64'(exp_done));
      check("hi_out", 64'(hi_out), 64'(exp_hi));
      check("lo_out", 64'(lo_out), 64'(exp_lo));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cancel_at: -1 none, 0 together with start, -2 in the done cycle, n>0 in cycle n
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] lit, input int lat_fixed, input int lat_early,
                        input int cancel_at, input int start_at);
    logic [63:0] res;
    int lat, lat_lit, cn;
    res = model_res(o, a, b);
    lat = model_lat(o, b);
`ifdef MDU_EARLY_TERM_EN
    lat_lit = lat_early;
`else
    lat_lit = lat_fixed;
`endif
    check("model_result", res, lit);
    check("model_latency", 64'(lat), 64'(lat_lit));
    cn = (cancel_at == -2) ? lat : cancel_at;

    start  = 1'b1;
    op     = o;
    src_a  = a;
    src_b  = b;
    cancel = (cn == 0);
    step();
    start  = 1'b0;
    cancel = 1'b0;
    if (cn == 0) return;

    for (int n = 1; n <= lat; n++) begin
      exp_busy = (n < lat);
      exp_done = (n == lat);
      if (n == lat) {exp_hi, exp_lo} = res;
      if (n == start_at) begin
        start = 1'b1;
        op    = MDU_DIVU;
        src_a = 32'd5;
        src_b = 32'd0;
      end
      if (n == cn) cancel = 1'b1;
      step();
      start  = 1'b0;
      cancel = 1'b0;
      if (n == cn && n < lat) break;
    end
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    step();

    run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 34, 5,  -1, -1);
    run_op(MDU_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, 34, 34, -1, -1);
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 34, 34, -1, -1);
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34, 34, -1, -1);
    run_op(MDU_DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1,  1,  -1, -1);
    run_op(MDU_DIV,   32'hFFFF_FF9C, 32'd7,         64'hFFFF_FFFE_FFFF_FFF2, 34, 34, -1, -1);
    run_op(MDU_DIV,   32'd100,       32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 34, 34, -1, -1);
    run_op(MDU_DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 34, 34, -1, -1);
    run_op(MDU_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 34, 33, -1, -1);

    // Cancel mid-multiply with an ignored start; hi/lo must keep 0/6
    run_op(MDU_MULTU, 32'd2, 32'd3, 64'h0000_0000_0000_0006, 34, 4, -1, -1);
`ifdef MDU_EARLY_TERM_EN
    run_op(MDU_MULTU, 32'd9, 32'd9, 64'h0000_0000_0000_0051, 34, 6, 3, 2);
`else
    run_op(MDU_MULTU, 32'd9, 32'd9, 64'h0000_0000_0000_0051, 34, 6, 10, 5);
`endif
    repeat (3) step();

    // start with cancel in IDLE issues nothing, not even a zero-divide
    run_op(MDU_DIVU, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1, 1, 0, -1);
    repeat (3) step();

    // cancel in the done cycle still delivers the pulse
    run_op(MDU_MULT, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 34, 5, -2, -1);
    run_op(MDU_DIVU, 32'd5, 32'd0,         64'h0000_0005_FFFF_FFFF, 1,  1, -2, -1);

    run_op(MDU_MULTU, 32'h1234_5678, 32'd3,         64'h0000_0000_369D_0368, 34, 4,  -1, -1);
    run_op(MDU_MULT,  32'd5,         32'd0,         64'h0000_0000_0000_0000, 34, 3,  -1, -1);
    run_op(MDU_MULT,  32'd1,         32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 34, 34, -1, -1);
    repeat (2) step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mdu_iter_core.md
# mdu_iter_core

Iterative multiply/divide engine behind the E-stage MDU front end. The front end issues one MULT/MULTU/DIV/DIVU per `start` pulse. This block computes the 64-bit HI/LO result using radix-2 shift-add (multiply) or restoring shift-subtract (divide) iterations. It reports completion with a one-cycle `done` pulse, and an exception flush can abort it.

## Interface
Parameters: none; widths are fixed by the shared package.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  issue pulse; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- src_a  in  32  multiplicand / dividend; sampled with start
- src_b  in  32  multiplier / divisor; sampled with start
- cancel  in  1  flush from exception request; aborts any operation in flight
- busy  out  1  operation in progress (MUL, DIV, FIXUP states)
- done  out  1  one-cycle pulse; hi_out and lo_out are valid in this cycle
- hi_out  out  32  HI result (high product / remainder); held until the next done
- lo_out  out  32  LO result (low product / quotient); held until the next done

## Operation
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Reset forces state IDLE, busy=0, done=0, hi_out=0, lo_out=0, and clears all internal registers.
- **IDLE**
  - start=1 and cancel=0: latch op, |a|, |b|, and the signs.
  - MULT and DIV take two's-complement magnitudes. MULTU and DIVU use the raw operands.
  - Then go to MUL for MULT/MULTU, or DIV for DIV/DIVU.
  - DIV/DIVU with src_b==0 goes straight to DONE with hi_out=src_a, lo_out=0xFFFFFFFF.
- **MUL**, per cycle:
  - If mplier[0] is 1, add mcand to the 64-bit acc.
  - Shift mcand left by one (64-bit). Shift mplier right by one. Increment the 6-bit iteration counter.
  - Exit to FIXUP when the counter reaches 32.
- **DIV**, per cycle, restoring step:
  - rem = {rem[31:0], quot[31]}; quot <<= 1.
  - If rem ≥ divisor, subtract the divisor and set quot[0]=1.
  - Exit to FIXUP after 32 steps.
- **FIXUP**:
  - MULT: negate the 64-bit acc if a31^b31.
  - DIV: negate the quotient if a31^b31; negate the remainder if a31.
  - Unsigned ops pass through unchanged.
  - Register the result into hi_out and lo_out, then go to DONE.
- **DONE**: done=1 and busy=0 for one cycle, then IDLE.
- DIV 0x80000000 / 0xFFFFFFFF returns lo=0x80000000, hi=0, with no trap.
- **start while not IDLE**: ignored, with no effect on the operation in flight.
- **cancel**:
  - In any state it forces IDLE on the next edge, with no done pulse.
  - hi_out and lo_out keep their previous values.
  - cancel together with start in IDLE: cancel wins and nothing is issued.
  - cancel in the DONE cycle: the done pulse still happens, since the result is already registered.

## Timing
- Cycle 0 is the edge that samples start=1; "cycle n" means the n-th edge after it.
- MUL/DIV iterate in cycles 1..32, FIXUP is in cycle 33, and done=1 in cycle 34.
- busy=1 in cycles 1..33; busy=0 in the done cycle.
- Divide-by-zero: done=1 in cycle 1, and busy stays 0 throughout.
- Earliest next start: sampled in the cycle after done (IDLE). Back-to-back spacing is 35 cycles.

## Configuration
- `MDU_EARLY_TERM_EN`, when defined: MUL exits to FIXUP when the post-shift mplier is 0 or the counter hits 32.
  - The multiply takes k = max(1, bit length of |b|) iterations, so done lands in cycle k+2.
  - Results are identical to the fixed-latency path.
  - Divide latency is unchanged.
- When undefined: multiply always takes 32 iterations, with done in cycle 34.

## Structure
- Package `mdu_pkg` holds:
  - the op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU);
  - the state enum;
  - MDU_ITERS=32 and MDU_W=32.
- One combinational sub-module, `mdu_div_step`: inputs rem, quot, and divisor; outputs the next rem and quot for one restoring step.
- The FSM, counter, sign handling, and multiply datapath live in the top module.

## Test plan
- MULT 0xFFFFFFFD × 7 → done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=1 in cycles 1..33.
- DIVU 100 / 7 → lo=14, hi=2, done in cycle 34. DIV 0xFFFFFFF9 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5 / 0 → done in cycle 1, hi=5, lo=0xFFFFFFFF.
- MULTU 2×3 (result hi=0, lo=6), then MULTU 9×9 with cancel in cycle 10:
  - no done; busy=0 in cycle 11; hi/lo stay 0/6.
  - A start pulsed in cycle 5 of an operation is ignored.
- With `MDU_EARLY_TERM_EN`: MULTU 0x12345678 × 3 → done in cycle 4, hi=0, lo=0x369D0368.
- With `MDU_EARLY_TERM_EN`: MULT 5 × 0 → done in cycle 3, result 0. MULT 1 × 0x80000000 → done in cycle 34, hi=0xFFFFFFFF, lo=0x80000000.
